exe_writeback_stage: RTL and testbench

//  Writeback stage directly downstream of one execute pipe (simple/complex ALU lane).

---
 rtl/exe_writeback_stage_if.sv | 50 +++++
 rtl/exe_writeback_stage.sv | 150 +++++++++++++++
 tb/tb_exe_writeback_stage.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/exe_writeback_stage_if.sv
// rtl/exe_writeback_stage_if.sv - writeback lane bus bundle (wbPacket in, PRF write, bypass, completion handshake)
// Field widths default below and may be overridden by predefining the SIZE_* macros.
// wbFlags / ctrlFlags bit 0 is destValid; the remaining bits (mispredict, exception, ...) pass through untouched.

`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_ACTIVELIST_LOG
`define SIZE_ACTIVELIST_LOG 5
`endif
`ifndef SIZE_EXE_FLAGS
`define SIZE_EXE_FLAGS 4
`endif

interface exe_writeback_stage_if;
  // wbPacket from the execute lane
  logic                            wbValid;
  logic [`SIZE_PHYSICAL_LOG-1:0]   wbPhyDest;
  logic [`SIZE_DATA-1:0]           wbDestData;
  logic [`SIZE_ACTIVELIST_LOG-1:0] wbAlID;
  logic [`SIZE_EXE_FLAGS-1:0]      wbFlags;
  // physical register file write port
  logic                            rfWrEn;
  logic [`SIZE_PHYSICAL_LOG-1:0]   rfWrAddr;
  logic [`SIZE_DATA-1:0]           rfWrData;
  // bypassPacket broadcast to the ForwardCheck units
  logic                            bypassValid;
  logic [`SIZE_PHYSICAL_LOG-1:0]   bypassTag;
  logic [`SIZE_DATA-1:0]           bypassData;
  // completion record toward the Active List
  logic                            ctrlValid;
  logic [`SIZE_ACTIVELIST_LOG-1:0] ctrlAlID;
  logic [`SIZE_EXE_FLAGS-1:0]      ctrlFlags;
  logic                            ctrlReady;

  modport slave (
    input  wbValid, wbPhyDest, wbDestData, wbAlID, wbFlags, ctrlReady,
    output rfWrEn, rfWrAddr, rfWrData, bypassValid, bypassTag, bypassData,
    output ctrlValid, ctrlAlID, ctrlFlags
  );

  modport master (
    output wbValid, wbPhyDest, wbDestData, wbAlID, wbFlags, ctrlReady,
    input  rfWrEn, rfWrAddr, rfWrData, bypassValid, bypassTag, bypassData,
    input  ctrlValid, ctrlAlID, ctrlFlags
  );
endinterface

// File: rtl/exe_writeback_stage.sv
// rtl/exe_writeback_stage.sv - execute-lane writeback stage with completion FIFO; optional WB_PERF_CNT_EN perf counters

`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_ACTIVELIST_LOG
`define SIZE_ACTIVELIST_LOG 5
`endif
`ifndef SIZE_EXE_FLAGS
`define SIZE_EXE_FLAGS 4
`endif

module exe_writeback_stage #(
  parameter int DEPTH       = 4,
  parameter int STALL_SLACK = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  recoverFlag_i,
  input  logic                  toggleFlag_i,
  exe_writeback_stage_if.slave  wb_if,
  output logic                  stall_o,
  output logic                  toggleFlag_o,
  output logic                  overflow_o
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]           wbCount_o,
  output logic [31:0]           stallCycles_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PR_W  = `SIZE_PHYSICAL_LOG;
  localparam int D_W   = `SIZE_DATA;
  localparam int AL_W  = `SIZE_ACTIVELIST_LOG;
  localparam int FL_W  = `SIZE_EXE_FLAGS;

  logic             stg_valid_q;
  logic             stg_dest_v_q;
  logic [PR_W-1:0]  stg_dest_q;
  logic [D_W-1:0]   stg_data_q;

  logic [AL_W-1:0]  fifo_alid_q  [DEPTH];
  logic [FL_W-1:0]  fifo_flags_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             toggle_q;

  logic capture, fifo_empty, fifo_full, pop, push;

  // A packet is accepted only outside recovery; a full FIFO takes a push only if its head leaves this cycle.
  assign capture    = wb_if.wbValid && !recoverFlag_i;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign pop        = !fifo_empty && wb_if.ctrlReady && !recoverFlag_i;
  assign push       = capture && (!fifo_full || pop);

  // Stage register: holds the packet whose PRF write and bypass go out this cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stg_valid_q  <= 1'b0;
      stg_dest_v_q <= 1'b0;
      stg_dest_q   <= '0;
      stg_data_q   <= '0;
    end else begin
      stg_valid_q <= capture;
      if (capture) begin
        stg_dest_v_q <= wb_if.wbFlags[0];
        stg_dest_q   <= wb_if.wbPhyDest;
        stg_data_q   <= wb_if.wbDestData;
      end
    end
  end

  // FIFO storage: entries are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_alid_q[wr_ptr_q]  <= wb_if.wbAlID;
      fifo_flags_q[wr_ptr_q] <= wb_if.wbFlags;
    end
  end

  // FIFO pointers and occupancy; recovery discards everything queued.
  always_ff @(posedge clk) begin
    if (!reset || recoverFlag_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow survives recovery; toggle flag is a plain one-cycle delay.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      toggle_q   <= 1'b0;
    end else begin
      toggle_q <= toggleFlag_i;
      if (capture && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  // Output drive: PRF write and bypass from the stage reg, completion head straight from the FIFO.
  always_comb begin
    wb_if.rfWrEn      = stg_valid_q && stg_dest_v_q;
    wb_if.rfWrAddr    = stg_dest_q;
    wb_if.rfWrData    = stg_data_q;
    wb_if.bypassValid = wb_if.rfWrEn;
    wb_if.bypassTag   = wb_if.rfWrEn ? stg_dest_q : '0;
    wb_if.bypassData  = wb_if.rfWrEn ? stg_data_q : '0;
    wb_if.ctrlValid   = !fifo_empty;
    wb_if.ctrlAlID    = fifo_empty ? '0 : fifo_alid_q[rd_ptr_q];
    wb_if.ctrlFlags   = fifo_empty ? '0 : fifo_flags_q[rd_ptr_q];
    stall_o           = (count_q >= CNT_W'(DEPTH - STALL_SLACK));
    toggleFlag_o      = toggle_q;
    overflow_o        = overflow_q;
  end

`ifdef WB_PERF_CNT_EN
  logic [31:0] wb_count_q, stall_cycles_q;

  // Perf counters: free-running, wrap naturally, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_count_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (capture) wb_count_q     <= wb_count_q + 32'd1;
      if (stall_o) stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign wbCount_o     = wb_count_q;
  assign stallCycles_o = stall_cycles_q;
`endif

endmodule

// File: tb/tb_exe_writeback_stage.sv
// tb/tb_exe_writeback_stage.sv - directed table plus randomized model check for exe_writeback_stage
module tb_exe_writeback_stage;
  localparam int DEPTH = 4;
  localparam int SLACK = 2;

  logic clk = 1'b0;
  logic reset, rec, tog;
  logic stall, tog_o, ovf;
`ifdef WB_PERF_CNT_EN
  logic [31:0] wbc, stc;
`endif

  exe_writeback_stage_if bus ();

  exe_writeback_stage #(.DEPTH(DEPTH), .STALL_SLACK(SLACK)) dut (
    .clk           (clk),
    .reset         (reset),
    .recoverFlag_i (rec),
    .toggleFlag_i  (tog),
    .wb_if         (bus),
    .stall_o       (stall),
    .toggleFlag_o  (tog_o),
    .overflow_o    (ovf)
`ifdef WB_PERF_CNT_EN
    ,
    .wbCount_o     (wbc),
    .stallCycles_o (stc)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: completion records as a bounded queue
  typedef struct packed {
    logic [4:0] al;
    logic [3:0] fl;
  } rec_t;
  rec_t        m_q[$];
  bit          m_en, m_ovf, m_tog;
  logic [6:0]  m_addr;
  logic [31:0] m_data;
  longint      m_wbcnt, m_stcnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("rfWrEn", bus.rfWrEn, m_en);
    if (m_en) begin
      chk("rfWrAddr", bus.rfWrAddr, m_addr);
      chk("rfWrData", bus.rfWrData, m_data);
    end
    chk("bypassValid", bus.bypassValid, m_en);
    chk("bypassTag", bus.bypassTag, m_en ? m_addr : 7'd0);
    chk("bypassData", bus.bypassData, m_en ? m_data : 32'd0);
    chk("ctrlValid", bus.ctrlValid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("ctrlAlID", bus.ctrlAlID, m_q[0].al);
      chk("ctrlFlags", bus.ctrlFlags, m_q[0].fl);
    end
    chk("stall", stall, m_q.size() >= DEPTH - SLACK);
    chk("toggle", tog_o, m_tog);
    chk("overflow", ovf, m_ovf);
`ifdef WB_PERF_CNT_EN
    chk("wbCount", wbc, m_wbcnt[31:0]);
    chk("stallCycles", stc, m_stcnt[31:0]);
`endif
  endtask

  // one clock: drive inputs, advance the model with the same inputs, then compare
  task automatic step(input bit rstn_v, input bit v, input bit rc, input bit rdy, input bit tg,
                      input logic [6:0] d, input logic [31:0] dt, input logic [4:0] al, input logic [3:0] fl);
    bit stall_pre;
    reset = rstn_v; rec = rc; tog = tg;
    bus.wbValid = v; bus.wbPhyDest = d; bus.wbDestData = dt; bus.wbAlID = al; bus.wbFlags = fl;
    bus.ctrlReady = rdy;
    @(posedge clk);
    stall_pre = (m_q.size() >= DEPTH - SLACK);
    if (!rstn_v) begin
      m_q.delete(); m_en = 0; m_ovf = 0; m_tog = 0; m_wbcnt = 0; m_stcnt = 0;
    end else begin
      m_tog = tg;
      if (stall_pre) m_stcnt++;
      if (rc) begin
        m_q.delete();
        m_en = 0;
      end else begin
        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        if (v) begin
          if (m_q.size() < DEPTH) m_q.push_back('{al: al, fl: fl});
          else m_ovf = 1;
          m_wbcnt++;
          m_addr = d;
          m_data = dt;
        end
        m_en = v && fl[0];
      end
    end
    #1;
    check_model();
  endtask

  typedef struct {
    bit v; bit rc; bit rdy;
    logic [6:0] d; logic [4:0] al; logic [3:0] fl;
    bit e_en; bit e_cv; logic [4:0] e_al; bit e_st; bit e_ovf;
  } vec_t;

  function automatic vec_t mk(bit v, bit rc, bit rdy, logic [6:0] d, logic [4:0] al, logic [3:0] fl,
                              bit e_en, bit e_cv, logic [4:0] e_al, bit e_st, bit e_ovf);
    vec_t r;
    r.v = v; r.rc = rc; r.rdy = rdy; r.d = d; r.al = al; r.fl = fl;
    r.e_en = e_en; r.e_cv = e_cv; r.e_al = e_al; r.e_st = e_st; r.e_ovf = e_ovf;
    return r;
  endfunction

  vec_t vt[17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dt;
    //        v  rc rdy d   al  fl   en cv al  st ovf
    vt[0]  = mk(1, 0, 1, 7,  5,  1,  1, 1, 5,  0, 0);
    vt[1]  = mk(0, 0, 1, 0,  0,  0,  0, 0, 0,  0, 0);
    vt[2]  = mk(1, 0, 0, 1,  1,  1,  1, 1, 1,  0, 0);
    vt[3]  = mk(1, 0, 0, 2,  2,  1,  1, 1, 1,  1, 0);
    vt[4]  = mk(1, 0, 0, 3,  3,  1,  1, 1, 1,  1, 0);
    vt[5]  = mk(1, 0, 0, 4,  4,  0,  0, 1, 1,  1, 0);
    vt[6]  = mk(1, 0, 1, 5,  5,  1,  1, 1, 2,  1, 0);
    vt[7]  = mk(1, 0, 0, 6,  6,  1,  1, 1, 2,  1, 1);
    vt[8]  = mk(0, 0, 1, 0,  0,  0,  0, 1, 3,  1, 1);
    vt[9]  = mk(0, 0, 1, 0,  0,  0,  0, 1, 4,  1, 1);
    vt[10] = mk(0, 0, 1, 0,  0,  0,  0, 1, 5,  0, 1);
    vt[11] = mk(0, 0, 1, 0,  0,  0,  0, 0, 0,  0, 1);
    vt[12] = mk(1, 0, 0, 10, 10, 1,  1, 1, 10, 0, 1);
    vt[13] = mk(1, 0, 0, 11, 11, 1,  1, 1, 10, 1, 1);
    vt[14] = mk(1, 0, 0, 12, 12, 1,  1, 1, 10, 1, 1);
    vt[15] = mk(1, 1, 0, 13, 13, 1,  0, 0, 0,  0, 1);
    vt[16] = mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 1);

    // reset held two cycles with a live packet on the inputs, then released
    step(0, 1, 0, 1, 1, 7'h55, 32'h1234_5678, 5'h3, 4'h1);
    step(0, 1, 0, 1, 1, 7'h55, 32'h1234_5678, 5'h3, 4'h1);
    chk("reset rfWrEn", bus.rfWrEn, 0);
    chk("reset rfWrAddr", bus.rfWrAddr, 0);
    chk("reset rfWrData", bus.rfWrData, 0);
    chk("reset bypassValid", bus.bypassValid, 0);
    chk("reset ctrlValid", bus.ctrlValid, 0);
    chk("reset ctrlAlID", bus.ctrlAlID, 0);
    chk("reset stall", stall, 0);
    chk("reset toggle", tog_o, 0);
    chk("reset overflow", ovf, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("post-reset ctrlValid", bus.ctrlValid, 0);
    chk("post-reset stall", stall, 0);

    // directed table: single push, back-pressure, full push+pop, overflow, drain, recovery
    for (int i = 0; i < 17; i++) begin
      dt = (i == 0) ? 32'hDEAD_BEEF : (32'h1000_0000 | 32'(vt[i].al));
      step(1, vt[i].v, vt[i].rc, vt[i].rdy, i[0], vt[i].d, dt, vt[i].al, vt[i].fl);
      chk($sformatf("vec%0d rfWrEn", i), bus.rfWrEn, vt[i].e_en);
      chk($sformatf("vec%0d ctrlValid", i), bus.ctrlValid, vt[i].e_cv);
      if (vt[i].e_cv) chk($sformatf("vec%0d ctrlAlID", i), bus.ctrlAlID, vt[i].e_al);
      chk($sformatf("vec%0d stall", i), stall, vt[i].e_st);
      chk($sformatf("vec%0d overflow", i), ovf, vt[i].e_ovf);
      chk($sformatf("vec%0d toggle", i), tog_o, i[0]);
      if (i == 0) begin
        chk("vec0 rfWrAddr", bus.rfWrAddr, 7'd7);
        chk("vec0 rfWrData", bus.rfWrData, 32'hDEAD_BEEF);
        chk("vec0 bypassData", bus.bypassData, 32'hDEAD_BEEF);
      end
    end

    // sticky overflow is cleared only by reset
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset clears overflow", ovf, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef WB_PERF_CNT_EN
    // 10 captured packets, then exactly 3 cycles with stall_o high before recovery empties the FIFO
    for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 0, 7'(i), 32'(i), 5'(i), 4'h1);
    step(1, 1, 0, 0, 0, 8, 8, 8, 4'h1);
    step(1, 1, 0, 0, 0, 9, 9, 9, 4'h1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("perf wbCount", wbc, 32'd10);
    chk("perf stallCycles", stc, 32'd3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("perf wbCount reset", wbc, 32'd0);
    chk("perf stallCycles reset", stc, 32'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 99) < 65,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 45,
           1'($urandom),
           7'($urandom), $urandom, 5'($urandom), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
